hstate_tile_buf: RTL and testbench
==================================

# hstate_tile_buf

Hidden-state tile buffer closing the SSM recurrence loop. Captures each `N_TILE`-wide h_next result tile from the FP16 adder bank and replays it as the h_prev tile for the next timestep's dA·h multiply. It holds one full state vector of `NUM_TILES` tiles. It returns zeros (h0 = 0) on the first timestep after reset or after a sequence start.

## Interface

**Parameters**
- `DW`, 16: element width (FP16 bit pattern; opaque to this block).
- `N_TILE`, 16: elements per tile.
- `NUM_TILES`, 8: tiles per state vector (buffer depth), ≥2.
- `ADDR_W`, 3: tile index width; `NUM_TILES` ≤ 2**`ADDR_W`.

**Ports**
- `clk`, input, 1: clock, rising edge.
- `rstn`, input, 1: synchronous, active-low reset.
- `seq_start_i`, input, 1: one-cycle pulse; begins a new sequence, so the next `NUM_TILES` reads return zero.
- `wr_valid_i`, input, 1: write strobe from the adder bank valid. No backpressure.
- `wr_data_i`, input, `N_TILE*DW`: h_next tile.
- `rd_valid_o`, output, 1: h_prev tile available at `rd_ptr`.
- `rd_ready_i`, input, 1: consumer accepts the tile.
- `rd_data_o`, output, `N_TILE*DW`: h_prev tile.
- `rd_idx_o`, output, `ADDR_W`: tile index of `rd_data_o`.
- `step_done_o`, output, 1: one-cycle pulse when the last tile of a timestep is written.
- `err_o`, output, 1: sticky overrun flag. Present only with `HSTATE_ERR_EN`.

## Operation

**State**
- `mem[NUM_TILES]` of `N_TILE*DW` bits.
- `full[NUM_TILES]`: entry holds an unconsumed tile.
- `zflag[NUM_TILES]`: entry reads as all-zero.
- `rd_ptr`, `wr_ptr` (`ADDR_W` bits). Both wrap from `NUM_TILES-1` to 0.

**Reset (`rstn`=0) and `seq_start_i`=1**
- `full` and `zflag` are set to all ones.
- `rd_ptr` and `wr_ptr` are set to 0.
- `step_done_o` is cleared to 0.
- `err_o` is cleared to 0.
- `mem` is not cleared; `zflag` masks it.

**Read**
- `rd_valid_o` = `full[rd_ptr]`.
- `rd_idx_o` = `rd_ptr`.
- `rd_data_o` = 0 if `zflag[rd_ptr]`, else `mem[rd_ptr]`. This is a mux from registers, with no added latency.
- On `rd_valid_o & rd_ready_i`: `full[rd_ptr]` ← 0, then `rd_ptr` increments with wrap.
- `rd_data_o` and `rd_idx_o` must stay stable while `rd_valid_o=1` and `rd_ready_i=0`.

**Write**
- On `wr_valid_i`:
  - `mem[wr_ptr]` ← `wr_data_i`
  - `zflag[wr_ptr]` ← 0
  - `full[wr_ptr]` ← 1
  - `wr_ptr` increments with wrap.
- When the written index is `NUM_TILES-1`, `step_done_o`=1 on the next cycle.

**Ordering invariant**
- Tile k of timestep t is written only after tile k of timestep t−1 has been read, i.e. `full[wr_ptr]`=0.
- A write to an entry with `full=1` is an overrun.

**Simultaneous events**
- Read and write to different indices in the same cycle: both take effect.
- Read and write to the same index cannot both be legal. A write to an entry with `full=0` is visible to the read side on the next cycle; there is no bypass.
- `seq_start_i` together with `wr_valid_i` or a read handshake: the start wins. The write is dropped and the read is not counted.
- Reset overrides everything.

## Timing

- Write at edge c: `rd_valid_o`/`rd_data_o` reflect it from cycle c+1.
- Read handshake at edge c: `rd_ptr` advances and the next entry is presented in cycle c+1. Sustained throughput is 1 tile/cycle when entries are full.
- `step_done_o` asserts in the cycle after the write of index `NUM_TILES-1` and lasts 1 cycle.
- Output values after reset:
  - `rd_valid_o`=1, `rd_data_o`=0, `rd_idx_o`=0
  - `step_done_o`=0
  - `err_o`=0

## Configuration

`HSTATE_ERR_EN` selects overrun handling.
- **Defined:** `err_o` port exists. An overrun write is dropped (`mem`, `zflag` and `wr_ptr` unchanged) and `err_o` is set sticky until reset or `seq_start_i`.
- **Undefined:** no `err_o` port. An overrun write overwrites unconditionally (`mem` updated, `zflag` cleared, `full` stays 1, `wr_ptr` advances).

## Test plan

- **Reset, NUM_TILES=8, `rd_ready_i`=1 for 8 cycles:** 8 zero tiles, `rd_idx_o` 0..7; then `rd_valid_o`=0.
- **Write tiles with all elements = 16'h3C00+k (k=0..7) after the zero reads, then read:** tile k returns 16'h3C00+k in every element, in order. `step_done_o` pulses once, the cycle after the k=7 write.
- **Write tile 0 and hold `rd_ready_i`=0 for 5 cycles:** `rd_data_o`/`rd_idx_o` stay stable, and `rd_valid_o` stays 1 from the cycle after the write.
- **Interleave, with write of tile k 3 cycles after read of tile k, for 4 timesteps:** no stalls, correct data each step, `wr_ptr`/`rd_ptr` wrap cleanly 7→0.
- **`seq_start_i` mid-timestep (after 3 writes) with a coincident `wr_valid_i`:** write dropped; next 8 reads return zero starting at index 0.
- **With `HSTATE_ERR_EN`, write 9 tiles with no reads after the zero pass:** 9th write dropped, `err_o`=1 sticky, tile 0 unchanged. Without the macro, tile 0 holds the 9th data.

Source files
------------

// File: rtl/hstate_tile_buf.sv
// rtl/hstate_tile_buf.sv - hidden-state tile buffer replaying h_next tiles as h_prev
// Optional overrun drop + sticky err_o port: define HSTATE_ERR_EN.
module hstate_tile_buf #(
    parameter int DW        = 16,
    parameter int N_TILE    = 16,
    parameter int NUM_TILES = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   seq_start_i,
    input  logic                   wr_valid_i,
    input  logic [N_TILE*DW-1:0]   wr_data_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [N_TILE*DW-1:0]   rd_data_o,
    output logic [ADDR_W-1:0]      rd_idx_o,
    output logic                   step_done_o
`ifdef HSTATE_ERR_EN
    ,
    output logic                   err_o
`endif
);
    localparam int TW = N_TILE * DW;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TILES - 1);

    logic [TW-1:0]        mem [NUM_TILES];
    logic [NUM_TILES-1:0] full;
    logic [NUM_TILES-1:0] zflag;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W-1:0]    wr_ptr;
    logic                 step_done;
    logic                 rd_fire;
    logic                 wr_fire;
`ifdef HSTATE_ERR_EN
    logic                 overrun;
    logic                 err;
`endif

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + ADDR_W'(1);
    endfunction

    assign rd_valid_o  = full[rd_ptr];
    assign rd_idx_o    = rd_ptr;
    assign rd_data_o   = zflag[rd_ptr] ? '0 : mem[rd_ptr];
    assign step_done_o = step_done;

    // A sequence start swallows any coincident read handshake or write.
    assign rd_fire = rd_valid_o & rd_ready_i & ~seq_start_i;

`ifdef HSTATE_ERR_EN
    assign overrun = wr_valid_i & full[wr_ptr] & ~seq_start_i;
    assign wr_fire = wr_valid_i & ~full[wr_ptr] & ~seq_start_i & rstn;
    assign err_o   = err;
`else
    assign wr_fire = wr_valid_i & ~seq_start_i & rstn;
`endif

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // Write side assigns last so an unguarded overrun on the read index keeps full set.
    always_ff @(posedge clk) begin
        if (!rstn || seq_start_i) begin
            full      <= '1;
            zflag     <= '1;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            step_done <= 1'b0;
`ifdef HSTATE_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            if (rd_fire) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ptr_inc(rd_ptr);
            end
            if (wr_fire) begin
                full[wr_ptr]  <= 1'b1;
                zflag[wr_ptr] <= 1'b0;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            step_done <= wr_fire && (wr_ptr == LAST_IDX);
`ifdef HSTATE_ERR_EN
            err <= err | overrun;
`endif
        end
    end
endmodule

// File: tb/tb_hstate_tile_buf.sv
// tb/tb_hstate_tile_buf.sv - table + scoreboard bench for hstate_tile_buf
// Honours HSTATE_ERR_EN for the overrun expectations.
module tb_hstate_tile_buf;
    localparam int DW     = 16;
    localparam int N_TILE = 16;
    localparam int NT     = 8;
    localparam int AW     = 3;
    localparam int TW     = N_TILE * DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          seq_start_i = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic [TW-1:0] wr_data_i = '0;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [TW-1:0] rd_data_o;
    logic [AW-1:0] rd_idx_o;
    logic          step_done_o;
`ifdef HSTATE_ERR_EN
    logic          err_o;
`endif

    hstate_tile_buf #(.DW(DW), .N_TILE(N_TILE), .NUM_TILES(NT), .ADDR_W(AW)) dut (
        .clk(clk),
        .rstn(rstn),
        .seq_start_i(seq_start_i),
        .wr_valid_i(wr_valid_i),
        .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data_o),
        .rd_idx_o(rd_idx_o),
        .step_done_o(step_done_o)
`ifdef HSTATE_ERR_EN
        , .err_o(err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] idx;
        logic [TW-1:0] data;
    } sb_t;

    typedef struct {
        logic          wr;
        logic [DW-1:0] val;
        logic          rd;
        logic          exp_valid;
        logic [AW-1:0] exp_idx;
        logic          exp_step;
        logic [DW-1:0] exp_elem;
    } vec_t;

    sb_t           q[$];
    vec_t          tbl[26];
    logic [AW-1:0] m_wr;
    logic          exp_step;
    logic          exp_err;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        sb_t e;
        q.delete();
        for (int i = 0; i < NT; i++) begin
            e.idx  = AW'(i);
            e.data = '0;
            q.push_back(e);
        end
        m_wr     = '0;
        exp_step = 1'b0;
        exp_err  = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        seq_start_i = 1'b0;
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        reset_model();
    endtask

    // Drive one cycle of inputs and check the presented head against the scoreboard.
    task automatic apply(input logic wr, input logic [DW-1:0] val, input logic rd, input logic seq);
        wr_valid_i  = wr;
        wr_data_i   = {N_TILE{val}};
        rd_ready_i  = rd;
        seq_start_i = seq;
        #2;
        chk("rd_valid", TW'(rd_valid_o), TW'(q.size() > 0));
        chk("step_done", TW'(step_done_o), TW'(exp_step));
`ifdef HSTATE_ERR_EN
        chk("err", TW'(err_o), TW'(exp_err));
`endif
        if (q.size() > 0) begin
            chk("sb_idx", TW'(rd_idx_o), TW'(q[0].idx));
            chk("sb_data", rd_data_o, q[0].data);
        end
    endtask

    // Update the model for the driven inputs, then move to the next cycle.
    task automatic advance();
        sb_t e;
        int  hit;
        if (seq_start_i) begin
            reset_model();
        end else begin
            if (rd_ready_i && q.size() > 0) void'(q.pop_front());
            exp_step = 1'b0;
            if (wr_valid_i) begin
                hit = -1;
                foreach (q[i]) if (q[i].idx == m_wr) hit = i;
                if (hit >= 0) begin
`ifdef HSTATE_ERR_EN
                    exp_err = 1'b1;
`else
                    q[hit].data = wr_data_i;
                    exp_step = (m_wr == AW'(NT - 1));
                    m_wr = m_wr + 1'b1;
`endif
                end else begin
                    e.idx  = m_wr;
                    e.data = wr_data_i;
                    q.push_back(e);
                    exp_step = (m_wr == AW'(NT - 1));
                    m_wr = m_wr + 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, 16'h0, 1'b1, 1'b1, AW'(i), 1'b0, 16'h0};
        tbl[8] = '{1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0};
        for (int k = 0; k < 8; k++)
            tbl[9+k] = '{1'b1, 16'h3C00 + 16'(k), 1'b0, (k > 0), 3'd0, 1'b0, 16'h3C00};
        for (int k = 0; k < 8; k++)
            tbl[17+k] = '{1'b0, 16'h0, 1'b1, 1'b1, AW'(k), (k == 0), 16'h3C00 + 16'(k)};
        tbl[25] = '{1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0};

        do_reset();

        // Zero pass, fill with 3C00+k, read back in order.
        for (int i = 0; i < 26; i++) begin
            apply(tbl[i].wr, tbl[i].val, tbl[i].rd, 1'b0);
            chk($sformatf("tbl%0d_valid", i), TW'(rd_valid_o), TW'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_idx", i), TW'(rd_idx_o), TW'(tbl[i].exp_idx));
            chk($sformatf("tbl%0d_step", i), TW'(step_done_o), TW'(tbl[i].exp_step));
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_data", i), rd_data_o, {N_TILE{tbl[i].exp_elem}});
            advance();
        end

        // Backpressure: presented tile must stay put.
        apply(1'b1, 16'h5555, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 16'h0, 1'b0, 1'b0);
            chk("hold_valid", TW'(rd_valid_o), TW'(1));
            chk("hold_idx", TW'(rd_idx_o), TW'(0));
            chk("hold_data", rd_data_o, {N_TILE{16'h5555}});
            advance();
        end
        apply(1'b0, 16'h0, 1'b1, 1'b0);
        advance();

        // Fill, then 4 timesteps with each write trailing its read by 3 cycles.
        for (int j = 0; j < NT; j++) begin
            apply(1'b1, 16'h4100 + 16'(j), 1'b0, 1'b0);
            advance();
        end
        for (int c = 0; c < 35; c++) begin
            apply(c >= 3, 16'h4000 + 16'(c), c < 32, 1'b0);
            if (c < 32) chk("interleave_nostall", TW'(rd_valid_o), TW'(1));
            advance();
        end
        for (int j = 0; j < NT; j++) begin
            apply(1'b0, 16'h0, 1'b1, 1'b0);
            advance();
        end

        // Sequence start mid-timestep with a coincident write.
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 16'h6000 + 16'(k), 1'b0, 1'b0);
            advance();
        end
        apply(1'b1, 16'hDEAD, 1'b0, 1'b1);
        advance();
        for (int k = 0; k < NT; k++) begin
            apply(1'b0, 16'h0, 1'b1, 1'b0);
            chk("seq_zero_idx", TW'(rd_idx_o), TW'(k));
            chk("seq_zero_data", rd_data_o, '0);
            advance();
        end
        apply(1'b0, 16'h0, 1'b0, 1'b0);
        chk("seq_drained", TW'(rd_valid_o), TW'(0));
        advance();

        // Nine writes with no reads: the ninth lands on an unconsumed tile 0.
        for (int k = 0; k < 9; k++) begin
            apply(1'b1, 16'h7000 + 16'(k), 1'b0, 1'b0);
            advance();
        end
        for (int k = 0; k < NT; k++) begin
            apply(1'b0, 16'h0, 1'b1, 1'b0);
            if (k == 0) begin
`ifdef HSTATE_ERR_EN
                chk("overrun_tile0", rd_data_o, {N_TILE{16'h7000}});
                chk("overrun_err", TW'(err_o), TW'(1));
`else
                chk("overrun_tile0", rd_data_o, {N_TILE{16'h7008}});
`endif
            end
            advance();
        end
        apply(1'b0, 16'h0, 1'b0, 1'b1);
        advance();
        apply(1'b0, 16'h0, 1'b0, 1'b0);
        chk("restart_valid", TW'(rd_valid_o), TW'(1));
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
